// File: rtl/wb_arb5_rr_pkg.sv
// Shared definitions for the five-master round-robin Wishbone arbiter.
// Sizes, FSM state encoding and one-hot/index helpers.
package wb_arb5_rr_pkg;

  localparam int ARB_N   = 5;
  localparam int ARB_IDW = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_st_e;

  function automatic logic [ARB_IDW-1:0] oh2idx(
    input logic [ARB_N-1:0] oh
  );
    logic [ARB_IDW-1:0] id;
    id = '0;
    for (int i = 0; i < ARB_N; i++)
      if (oh[i]) id = id | ARB_IDW'(i);
    return id;
  endfunction

  function automatic logic [ARB_N-1:0] idx2oh(
    input logic [ARB_IDW-1:0] id
  );
    return ARB_N'(1) << id;
  endfunction

endpackage

// File: rtl/wb_arb5_rr_pick5.sv
// Round-robin pick: rotate requests to start after the last owner,
// take the lowest set bit, rotate the one-hot back.
module rr_pick5
  import wb_arb5_rr_pkg::*;
(
  input  logic [ARB_N-1:0]   req,
  input  logic [ARB_IDW-1:0] last,
  output logic               pick_vld,
  output logic [ARB_IDW-1:0] pick_id,
  output logic [ARB_N-1:0]   pick_oh
);

  logic [ARB_IDW-1:0] start;
  logic [2*ARB_N-1:0] dbl;
  logic [2*ARB_N-1:0] back;
  logic [ARB_N-1:0]   rot;
  logic [ARB_N-1:0]   rot_oh;

  assign start = (last >= ARB_IDW'(ARB_N-1)) ? '0 : last + 1'b1;
  assign dbl   = {req, req} >> start;
  assign rot   = dbl[ARB_N-1:0];

  always_comb begin
    rot_oh = '0;
    for (int i = ARB_N-1; i >= 0; i--)
      if (rot[i]) rot_oh = ARB_N'(1) << i;
  end

  assign back     = {rot_oh, rot_oh} << start;
  assign pick_oh  = back[2*ARB_N-1:ARB_N];
  assign pick_id  = oh2idx(pick_oh);
  assign pick_vld = |req;

endmodule

// File: rtl/wb_arb5_rr.sv
// Five-master round-robin arbiter with a dead cycle on every handoff
// and optional bounded-hold preemption of unlocked owners.
module wb_arb5_rr
  import wb_arb5_rr_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [ARB_N-1:0]   req,
  input  logic [ARB_N-1:0]   lock,
  output logic [ARB_N-1:0]   gnt,
  output logic               gnt_vld,
  output logic [ARB_IDW-1:0] gnt_id,
  output logic               preempt
);

  localparam bit PRE_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    PRE_EN ? CNT_W'(MAX_HOLD-1) : '0;

  arb_st_e            state_q, state_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic [ARB_IDW-1:0] last_q, last_d;
  logic [ARB_N-1:0]   gnt_d;
  logic               vld_d;
  logic [ARB_IDW-1:0] id_d;
  logic               pre_d;

  logic               pick_vld;
  logic [ARB_IDW-1:0] pick_id;
  logic [ARB_N-1:0]   pick_oh;

  logic own_req, own_lock, others, pre_hit;

  rr_pick5 u_pick (
    .req      (req),
    .last     (last_q),
    .pick_vld (pick_vld),
    .pick_id  (pick_id),
    .pick_oh  (pick_oh)
  );

  // gnt is the owner's one-hot while BUSY, so it doubles as the owner mask
  assign own_req  = |(req & gnt);
  assign own_lock = |(lock & gnt);
  assign others   = |(req & ~gnt);
  assign pre_hit  = PRE_EN && (hold_q == HOLD_LAST)
                    && !own_lock && others;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    gnt_d   = gnt;
    vld_d   = gnt_vld;
    id_d    = gnt_id;
    pre_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_BUSY;
          gnt_d   = pick_oh;
          vld_d   = 1'b1;
          id_d    = pick_id;
          hold_d  = '0;
        end
      end
      ST_BUSY: begin
        if (!own_req || pre_hit) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          last_d  = gnt_id;
          pre_d   = own_req;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      last_q  <= ARB_IDW'(ARB_N-1);
      gnt     <= '0;
      gnt_vld <= 1'b0;
      gnt_id  <= ARB_IDW'(ARB_N-1);
      preempt <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      gnt_vld <= vld_d;
      gnt_id  <= id_d;
      preempt <= pre_d;
    end
  end

endmodule

// File: tb/tb_wb_arb5_rr.sv
// Directed bench for wb_arb5_rr: one instance never preempts,
// the other preempts after four cycles.
module tb_wb_arb5_rr;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] lock;

  logic [4:0] gnt0, gnt4;
  logic       vld0, vld4;
  logic [2:0] id0, id4;
  logic       pre0, pre4;

  int n_chk  = 0;
  int n_pass = 0;
  int pre4_cnt = 0;

  logic [4:0] prev0 = '0;
  logic [4:0] prev4 = '0;

  wb_arb5_rr #(.MAX_HOLD(0), .CNT_W(5)) u_h0 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req      (req),
    .lock     (lock),
    .gnt      (gnt0),
    .gnt_vld  (vld0),
    .gnt_id   (id0),
    .preempt  (pre0)
  );

  wb_arb5_rr #(.MAX_HOLD(4), .CNT_W(5)) u_h4 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req      (req),
    .lock     (lock),
    .gnt      (gnt4),
    .gnt_vld  (vld4),
    .gnt_id   (id4),
    .preempt  (pre4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
  endtask

  function automatic logic [31:0] enc(input logic [4:0] g);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 5; i++)
      if (g[i]) r = i;
    return r;
  endfunction

  function automatic logic [31:0] oh1(input logic [4:0] g);
    return {31'b0, (g == 5'b0) || ((g & (g - 5'd1)) == 5'b0)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    req  = '0;
    lock = '0;
    rst  = 1'b1;
    step(2);
    rst  = 1'b0;
    step(1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev0 = '0;
      prev4 = '0;
    end else begin
      chk("inv_oh0", oh1(gnt0), 1);
      chk("inv_oh4", oh1(gnt4), 1);
      chk("inv_vld0", {31'b0, vld0}, {31'b0, |gnt0});
      chk("inv_vld4", {31'b0, vld4}, {31'b0, |gnt4});
      if (vld0) chk("inv_id0", {29'b0, id0}, enc(gnt0));
      if (vld4) chk("inv_id4", {29'b0, id4}, enc(gnt4));
      if (prev0 != 0 && gnt0 != 0)
        chk("inv_dead0", {27'b0, gnt0}, {27'b0, prev0});
      if (prev4 != 0 && gnt4 != 0)
        chk("inv_dead4", {27'b0, gnt4}, {27'b0, prev4});
      if (pre4) pre4_cnt++;
      prev0 = gnt0;
      prev4 = gnt4;
    end
  end

  int ord[6] = '{0, 1, 2, 3, 4, 0};
  int pc;

  initial begin
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    step(2);
    chk("rst_gnt", gnt0, 0);
    chk("rst_vld", vld0, 0);
    chk("rst_id", id0, 4);
    chk("rst_pre", pre0, 0);
    chk("rst_id4", id4, 4);
    rst = 1'b0;

    // single requester: one-cycle latency, release on next edge
    req = 5'b00001;
    step(1);
    chk("t1_gnt", gnt0, 5'b00001);
    chk("t1_id", id0, 0);
    chk("t1_vld", vld0, 1);
    req = 5'b00000;
    step(1);
    chk("t1_rel", gnt0, 0);
    chk("t1_relvld", vld0, 0);
    chk("t1_hold_id", id0, 0);

    // all request, each owner leaves after 3 cycles
    do_reset();
    req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk("t2_id", id0, ord[k]);
      chk("t2_gnt", gnt0, 5'b1 << ord[k]);
      step(2);
      chk("t2_held", gnt0, 5'b1 << ord[k]);
      req[ord[k]] = 1'b0;
      step(1);
      chk("t2_dead", gnt0, 0);
      req[ord[k]] = 1'b1;
    end
    req = '0;

    // bounded hold preemption
    do_reset();
    req = 5'b00011;
    step(1);
    chk("t3_g0", gnt4, 5'b00001);
    step(3);
    chk("t3_g0_4th", gnt4, 5'b00001);
    chk("t3_nopre", pre4, 0);
    step(1);
    chk("t3_dead", gnt4, 0);
    chk("t3_pre", pre4, 1);
    chk("t3_pre_id", id4, 0);
    step(1);
    chk("t3_g1", gnt4, 5'b00010);
    chk("t3_pre_off", pre4, 0);
    step(3);
    chk("t3_g1_4th", gnt4, 5'b00010);
    step(1);
    chk("t3_dead2", gnt4, 0);
    chk("t3_pre2", pre4, 1);
    step(1);
    chk("t3_back0", gnt4, 5'b00001);
    chk("t3_h0_keep", gnt0, 5'b00001);
    chk("t3_h0_nopre", pre0, 0);

    // locked owner never preempted
    do_reset();
    lock = 5'b00001;
    req  = 5'b00011;
    pc   = pre4_cnt;
    step(1);
    chk("t4_g0", gnt4, 5'b00001);
    step(22);
    chk("t4_keep", gnt4, 5'b00001);
    chk("t4_sat", u_h4.hold_q, 4);
    chk("t4_nopre", pre4_cnt - pc, 0);

    // round robin after owner 2
    do_reset();
    req = 5'b00100;
    step(1);
    chk("t5_g2", gnt0, 5'b00100);
    req = 5'b10110;
    step(1);
    chk("t5_ign", gnt0, 5'b00100);
    req = 5'b10010;
    step(1);
    chk("t5_dead", gnt0, 0);
    step(1);
    chk("t5_g4", gnt0, 5'b10000);
    chk("t5_id4", id0, 4);
    req = 5'b00110;
    step(1);
    chk("t5_dead2", gnt0, 0);
    step(1);
    chk("t5_g1", gnt0, 5'b00010);
    req = 5'b00100;
    step(1);
    chk("t5_dead3", gnt0, 0);
    step(1);
    chk("t5_g2b", gnt0, 5'b00100);

    // async reset mid-grant
    do_reset();
    req = 5'b01000;
    step(1);
    chk("t6_g3", gnt0, 5'b01000);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async", gnt0, 0);
    chk("t6_avld", vld0, 0);
    chk("t6_aid", id0, 4);
    step(2);
    rst = 1'b0;
    req = 5'b11000;
    step(1);
    chk("t6_g3b", gnt0, 5'b01000);
    chk("t6_id3", id0, 3);
    req = '0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
